a2d_seq: RTL

A2D_SEQ -- requirements
Module: a2d_seq

---
 rtl/a2d_seq_if.sv | 26 ++
 rtl/a2d_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/a2d_seq_if.sv
// a2d_seq_if: SPI transaction handshake between the A2D round sequencer
// (master) and the SPI shifter that performs the 16-bit transfers (slave).
//   spi_start - one-cycle request to run a transaction
//   spi_cmd   - transaction word, stable from spi_start until spi_done
//   spi_done  - one-cycle completion pulse
//   spi_rd    - received word, valid in the spi_done cycle
interface a2d_seq_if;
    logic        spi_start;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd;

    modport master (
        output spi_start,
        output spi_cmd,
        input  spi_done,
        input  spi_rd
    );

    modport slave (
        input  spi_start,
        input  spi_cmd,
        output spi_done,
        output spi_rd
    );
endinterface

// File: rtl/a2d_seq.sv
// a2d_seq: periodic A2D round sequencer. On every period terminal count it
// converts channels 0, 4, 5, 6 (two SPI transactions per channel: command,
// then read-back) and publishes all four results together.
//   clk, rst_n   - clock, synchronous active-low reset
//   spi          - SPI transaction handshake (master side)
//   lft_ld       - channel 0 result
//   rght_ld      - channel 4 result
//   steer_pot    - channel 5 result
//   batt         - channel 6 result
//   vld          - one-cycle pulse when a new result set is published
//   a2d_err      - sticky timeout flag, cleared by the next good round
module a2d_seq #(
    parameter int fast_sim = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    a2d_seq_if.master        spi,
    output logic [11:0]      lft_ld,
    output logic [11:0]      rght_ld,
    output logic [11:0]      steer_pot,
    output logic [11:0]      batt,
    output logic             vld,
    output logic             a2d_err
);

    localparam int unsigned PER_W = (fast_sim != 0) ? 9 : 20;
    localparam int unsigned TMO_W = (fast_sim != 0) ? 6 : 12;
    localparam logic [1:0]  LAST_IDX = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        WAIT_CMD,
        SEND_RD,
        WAIT_RD,
        COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][11:0]  shd_q, shd_d;
    logic              start_q, start_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [11:0]       lft_q, lft_d;
    logic [11:0]       rght_q, rght_d;
    logic [11:0]       steer_q, steer_d;
    logic [11:0]       batt_q, batt_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;
    logic              tick;
    logic              tmo_hit;
    logic [3:0]        rd_hi_unused;

    // Only the 12-bit conversion result is meaningful in the read word.
    assign rd_hi_unused = spi.spi_rd[15:12];

    assign tick    = (per_q == '1);
    assign tmo_hit = (tmo_q == '1);

    // Channel index -> command word; conversion order is 0, 4, 5, 6.
    function automatic logic [15:0] cmd_for(input logic [1:0] idx);
        logic [2:0] chnl;
        case (idx)
            2'd0:    chnl = 3'd0;
            2'd1:    chnl = 3'd4;
            2'd2:    chnl = 3'd5;
            default: chnl = 3'd6;
        endcase
        return {2'b00, chnl, 11'h000};
    endfunction

    always_comb begin
        state_d = state_q;
        per_d   = per_q + 1'b1;
        tmo_d   = tmo_q;
        idx_d   = idx_q;
        shd_d   = shd_q;
        cmd_d   = cmd_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        steer_d = steer_q;
        batt_d  = batt_q;
        vld_d   = 1'b0;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                // Ticks seen in any other state are simply lost.
                if (tick) begin
                    state_d = SEND_CMD;
                    idx_d   = '0;
                    cmd_d   = cmd_for(2'd0);
                end
            end
            SEND_CMD: begin
                // Every wait state is entered from a send state, so the
                // timeout is cleared here on the way in.
                state_d = WAIT_CMD;
                tmo_d   = '0;
            end
            WAIT_CMD: begin
                tmo_d = tmo_q + 1'b1;
                if (spi.spi_done) begin
                    state_d = SEND_RD;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            SEND_RD: begin
                state_d = WAIT_RD;
                tmo_d   = '0;
            end
            WAIT_RD: begin
                tmo_d = tmo_q + 1'b1;
                if (spi.spi_done) begin
                    shd_d[idx_q] = spi.spi_rd[11:0];
                    if (idx_q == LAST_IDX) begin
                        // Outputs are registered, so they are loaded on the
                        // edge into COMMIT and appear together with vld.
                        // The last channel bypasses its shadow register.
                        state_d = COMMIT;
                        vld_d   = 1'b1;
                        err_d   = 1'b0;
                        lft_d   = shd_q[0];
                        rght_d  = shd_q[1];
                        steer_d = shd_q[2];
                        batt_d  = spi.spi_rd[11:0];
                    end else begin
                        state_d = SEND_CMD;
                        idx_d   = idx_q + 2'd1;
                        cmd_d   = cmd_for(idx_q + 2'd1);
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d = (state_d == SEND_CMD) || (state_d == SEND_RD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            per_q   <= '0;
            tmo_q   <= '0;
            idx_q   <= '0;
            shd_q   <= '0;
            start_q <= 1'b0;
            cmd_q   <= '0;
            lft_q   <= '0;
            rght_q  <= '0;
            steer_q <= '0;
            batt_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            tmo_q   <= tmo_d;
            idx_q   <= idx_d;
            shd_q   <= shd_d;
            start_q <= start_d;
            cmd_q   <= cmd_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            steer_q <= steer_d;
            batt_q  <= batt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign spi.spi_start = start_q;
    assign spi.spi_cmd   = cmd_q;
    assign lft_ld        = lft_q;
    assign rght_ld       = rght_q;
    assign steer_pot     = steer_q;
    assign batt          = batt_q;
    assign vld           = vld_q;
    assign a2d_err       = err_q;

endmodule
